// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  // Supervisor states. The numeric values are visible on the STATE port.
  typedef enum logic [2:0] {
    ST_PWRDN     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAILED    = 3'd4
  } pll_state_e;

  // Width of the shared phase timer. The timer never holds more than the
  // largest window minus one, so clog2 of the largest window is enough.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous status bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only the second one is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervisor for a fabric PLL: sequences power-down, waits for and qualifies
// lock, retries on timeout or loss of lock, and reports status.
// RESTART is a one-cycle request sampled on Clock; it wins over every other
// transition in the cycle it is seen.
module pll_lock_supervisor #(
  parameter int PD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int CNT_W         = 8
) (
  input  logic             Clock,
  input  logic             Reset_N,
  input  logic             PLL_LOCK,
  input  logic             RESTART,
  output logic             PLL_POWERDOWN_N,
  output logic             PLL_READY,
  output logic             FABRIC_RESET_N,
  output logic             FAILED,
  output logic [2:0]       STATE,
  output logic [3:0]       RETRY_CNT,
  output logic [CNT_W-1:0] LOSS_CNT
);

  import pll_sup_pkg::*;

  localparam int TW = timer_width(PD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [TW-1:0] PD_LAST      = TW'(PD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic             lock_s;
  pll_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [3:0]       retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             pd_n_q, pd_n_d;
  logic             ready_q, ready_d;
  logic             frn_q, frn_d;
  logic             failed_q, failed_d;

  sync_2ff u_lock_sync (
    .clk   (Clock),
    .rst_n (Reset_N),
    .d     (PLL_LOCK),
    .q     (lock_s)
  );

  // Next-state, counter updates and output decode of the next state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (RESTART) begin
      state_d = ST_PWRDN;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PWRDN: begin
          if (timer_q == PD_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (timer_q == TIMEOUT_LAST) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == RETRY_LIMIT) ? ST_FAILED : ST_PWRDN;
          end
        end
        ST_STABLE: begin
          // A glitch sends us back to waiting without costing a retry.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_LOCKED;
            retry_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!lock_s) begin
            state_d = ST_PWRDN;
            if (loss_q != {CNT_W{1'b1}}) loss_d = loss_q + 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Timer restarts on every phase change (and on RESTART); it only
    // advances in the phases that have a window to measure.
    if (RESTART || (state_d != state_q)) begin
      timer_d = '0;
    end else if ((state_q == ST_PWRDN) || (state_q == ST_WAIT_LOCK) ||
                 (state_q == ST_STABLE)) begin
      timer_d = timer_q + 1'b1;
    end

    pd_n_d   = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
               (state_d == ST_LOCKED);
    ready_d  = (state_d == ST_LOCKED);
    frn_d    = (state_d == ST_LOCKED);
    failed_d = (state_d == ST_FAILED);
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q  <= ST_PWRDN;
      timer_q  <= '0;
      retry_q  <= '0;
      loss_q   <= '0;
      pd_n_q   <= 1'b0;
      ready_q  <= 1'b0;
      frn_q    <= 1'b0;
      failed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      loss_q   <= loss_d;
      pd_n_q   <= pd_n_d;
      ready_q  <= ready_d;
      frn_q    <= frn_d;
      failed_q <= failed_d;
    end
  end

  assign PLL_POWERDOWN_N = pd_n_q;
  assign PLL_READY       = ready_q;
  assign FABRIC_RESET_N  = frn_q;
  assign FAILED          = failed_q;
  assign STATE           = state_q;
  assign RETRY_CNT       = retry_q;
  assign LOSS_CNT        = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus a randomized run,
// all compared against a phase-level reference model of the supervisor.
module tb_pll_lock_supervisor;

  localparam int PD_CYCLES     = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 3;
  localparam int CNT_W         = 2;
  localparam int SYNC_STAGES   = 2;
  localparam int VW            = 11 + CNT_W;
  localparam int LOSS_MAX      = (1 << CNT_W) - 1;

  localparam int PH_OFF  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_LOCK = 3;
  localparam int PH_FAIL = 4;

  logic             Clock;
  logic             Reset_N;
  logic             PLL_LOCK;
  logic             RESTART;
  logic             PLL_POWERDOWN_N;
  logic             PLL_READY;
  logic             FABRIC_RESET_N;
  logic             FAILED;
  logic [2:0]       STATE;
  logic [3:0]       RETRY_CNT;
  logic [CNT_W-1:0] LOSS_CNT;

  int checks = 0;
  int passes = 0;
  int loss_events = 0;

  pll_lock_supervisor #(
    .PD_CYCLES     (PD_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES),
    .CNT_W         (CNT_W)
  ) dut (
    .Clock           (Clock),
    .Reset_N         (Reset_N),
    .PLL_LOCK        (PLL_LOCK),
    .RESTART         (RESTART),
    .PLL_POWERDOWN_N (PLL_POWERDOWN_N),
    .PLL_READY       (PLL_READY),
    .FABRIC_RESET_N  (FABRIC_RESET_N),
    .FAILED          (FAILED),
    .STATE           (STATE),
    .RETRY_CNT       (RETRY_CNT),
    .LOSS_CNT        (LOSS_CNT)
  );

  // Clock and reset block.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference model: phase, time spent in phase, retry/loss tallies and a
  // history of raw lock samples standing in for the synchroniser delay.
  int m_phase = PH_OFF;
  int m_time  = 0;
  int m_retry = 0;
  int m_loss  = 0;
  int m_next;
  bit m_ls;
  bit m_hist[$] = '{1'b0, 1'b0};

  always @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      m_phase = PH_OFF;
      m_time  = 0;
      m_retry = 0;
      m_loss  = 0;
      m_hist  = '{1'b0, 1'b0};
    end else begin
      m_ls = m_hist[SYNC_STAGES-1];
      m_hist.push_front(PLL_LOCK);
      void'(m_hist.pop_back());
      m_next = m_phase;
      if (RESTART) begin
        m_next  = PH_OFF;
        m_retry = 0;
      end else if (m_phase == PH_OFF) begin
        if (m_time + 1 >= PD_CYCLES) m_next = PH_WAIT;
      end else if (m_phase == PH_WAIT) begin
        if (m_ls) m_next = PH_STAB;
        else if (m_time + 1 >= LOCK_TIMEOUT) begin
          m_retry = m_retry + 1;
          m_next  = (m_retry >= MAX_RETRIES) ? PH_FAIL : PH_OFF;
        end
      end else if (m_phase == PH_STAB) begin
        if (!m_ls) m_next = PH_WAIT;
        else if (m_time + 1 >= STABLE_CYCLES) begin
          m_next  = PH_LOCK;
          m_retry = 0;
        end
      end else if (m_phase == PH_LOCK) begin
        if (!m_ls) begin
          m_next = PH_OFF;
          m_loss = (m_loss + 1 > LOSS_MAX) ? LOSS_MAX : m_loss + 1;
        end
      end
      m_time  = (RESTART || m_next != m_phase) ? 0 : m_time + 1;
      m_phase = m_next;
    end
  end

  function automatic logic [VW-1:0] model_vec();
    logic pd;
    pd = (m_phase == PH_WAIT) || (m_phase == PH_STAB) || (m_phase == PH_LOCK);
    return {pd, (m_phase == PH_LOCK), (m_phase == PH_LOCK), (m_phase == PH_FAIL),
            3'(m_phase), 4'(m_retry), CNT_W'(m_loss)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {PLL_POWERDOWN_N, PLL_READY, FABRIC_RESET_N, FAILED, STATE, RETRY_CNT, LOSS_CNT};
  endfunction

  // Driver: advance one cycle, landing just after the active edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset_N  = 1'b0;
    PLL_LOCK = 1'b0;
    RESTART  = 1'b0;
    repeat (3) tick();
    checks++;
    if (dut_vec() !== '0) $display("FAIL reset_outputs: got %h expected %h", dut_vec(), {VW{1'b0}});
    else passes++;
  endtask

  task automatic test_power_up();
    int n;
    Reset_N = 1'b1;
    n = 0;
    while (PLL_POWERDOWN_N !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (n !== PD_CYCLES) $display("FAIL pd_low_cycles: got %0d expected %0d", n, PD_CYCLES);
    else passes++;
    repeat (20) tick();
    PLL_LOCK = 1'b1;
    n = 0;
    while (PLL_READY !== 1'b1 && n < 60) begin tick(); n++; end
    checks++;
    if (n !== SYNC_STAGES + 1 + STABLE_CYCLES)
      $display("FAIL ready_latency: got %0d expected %0d", n, SYNC_STAGES + 1 + STABLE_CYCLES);
    else passes++;
    checks++;
    if ({STATE, RETRY_CNT, FABRIC_RESET_N} !== {3'd3, 4'd0, 1'b1})
      $display("FAIL locked_status: got state=%0d retry=%0d frn=%b expected 3 0 1", STATE, RETRY_CNT, FABRIC_RESET_N);
    else passes++;
    checks++;
    if (dut_vec() !== model_vec()) $display("FAIL power_up_model: got %h expected %h", dut_vec(), model_vec());
    else passes++;
  endtask

  task automatic test_lock_loss();
    int n;
    PLL_LOCK = 1'b0;
    tick();
    PLL_LOCK = 1'b1;
    n = 1;
    while (PLL_READY === 1'b1 && n < 10) begin tick(); n++; end
    loss_events++;
    checks++;
    if ({PLL_READY, FABRIC_RESET_N, STATE, LOSS_CNT} !== {1'b0, 1'b0, 3'd0, CNT_W'(1)})
      $display("FAIL loss_detect: got ready=%b frn=%b state=%0d loss=%0d expected 0 0 0 1",
               PLL_READY, FABRIC_RESET_N, STATE, LOSS_CNT);
    else passes++;
    n = 0;
    while (PLL_READY !== 1'b1 && n < 60) begin tick(); n++; end
    checks++;
    if (n !== PD_CYCLES + 1 + STABLE_CYCLES)
      $display("FAIL relock_latency: got %0d expected %0d", n, PD_CYCLES + 1 + STABLE_CYCLES);
    else passes++;
  endtask

  task automatic test_stable_glitch();
    int n;
    RESTART = 1'b1;
    tick();
    RESTART = 1'b0;
    checks++;
    if ({STATE, LOSS_CNT} !== {3'd0, CNT_W'(1)})
      $display("FAIL restart_from_locked: got state=%0d loss=%0d expected 0 1", STATE, LOSS_CNT);
    else passes++;
    n = 0;
    while (STATE !== 3'd2 && n < 20) begin tick(); n++; end
    repeat (5) tick();
    PLL_LOCK = 1'b0;
    repeat (2) tick();
    PLL_LOCK = 1'b1;
    n = 0;
    while (STATE !== 3'd1 && n < 6) begin tick(); n++; end
    checks++;
    if ({STATE, RETRY_CNT} !== {3'd1, 4'd0})
      $display("FAIL glitch_back_to_wait: got state=%0d retry=%0d expected 1 0", STATE, RETRY_CNT);
    else passes++;
    n = 0;
    while (STATE !== 3'd2 && n < 10) begin tick(); n++; end
    n = 0;
    while (STATE !== 3'd3 && n < 30) begin tick(); n++; end
    checks++;
    if (n !== STABLE_CYCLES) $display("FAIL stable_window_restart: got %0d expected %0d", n, STABLE_CYCLES);
    else passes++;
  endtask

  task automatic test_timeout_fail();
    int n;
    int attempts;
    logic [2:0] prev;
    PLL_LOCK = 1'b0;
    loss_events++;
    n = 0;
    attempts = 0;
    prev = STATE;
    while (FAILED !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (prev !== 3'd1 && STATE === 3'd1) attempts++;
      prev = STATE;
    end
    checks++;
    if (attempts !== MAX_RETRIES) $display("FAIL attempt_count: got %0d expected %0d", attempts, MAX_RETRIES);
    else passes++;
    checks++;
    if ({FAILED, STATE, RETRY_CNT} !== {1'b1, 3'd4, 4'(MAX_RETRIES)})
      $display("FAIL failed_status: got failed=%b state=%0d retry=%0d expected 1 4 %0d",
               FAILED, STATE, RETRY_CNT, MAX_RETRIES);
    else passes++;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (PLL_POWERDOWN_N !== 1'b0 || STATE !== 3'd4) n++;
    end
    checks++;
    if (n !== 0) $display("FAIL failed_holds_pd: got %0d bad cycles expected 0", n);
    else passes++;
    checks++;
    if (dut_vec() !== model_vec()) $display("FAIL failed_model: got %h expected %h", dut_vec(), model_vec());
    else passes++;
  endtask

  task automatic test_restart();
    int n;
    RESTART = 1'b1;
    tick();
    RESTART = 1'b0;
    checks++;
    if ({STATE, RETRY_CNT, FAILED, PLL_POWERDOWN_N} !== {3'd0, 4'd0, 1'b0, 1'b0})
      $display("FAIL restart_from_failed: got state=%0d retry=%0d failed=%b pdn=%b expected 0 0 0 0",
               STATE, RETRY_CNT, FAILED, PLL_POWERDOWN_N);
    else passes++;
    n = 0;
    while (STATE !== 3'd1 && n < 10) begin tick(); n++; end
    repeat (LOCK_TIMEOUT - 1) tick();
    checks++;
    if (STATE !== 3'd1) $display("FAIL pre_timeout_state: got %0d expected 1", STATE);
    else passes++;
    RESTART = 1'b1;
    tick();
    RESTART = 1'b0;
    checks++;
    if ({STATE, RETRY_CNT, FAILED} !== {3'd0, 4'd0, 1'b0})
      $display("FAIL restart_at_timeout: got state=%0d retry=%0d failed=%b expected 0 0 0",
               STATE, RETRY_CNT, FAILED);
    else passes++;
    checks++;
    if (dut_vec() !== model_vec()) $display("FAIL restart_model: got %h expected %h", dut_vec(), model_vec());
    else passes++;
  endtask

  task automatic test_loss_saturation();
    int n;
    int exp_loss;
    for (int k = 0; k < 4; k++) begin
      PLL_LOCK = 1'b1;
      n = 0;
      while (PLL_READY !== 1'b1 && n < 80) begin tick(); n++; end
      PLL_LOCK = 1'b0;
      tick();
      PLL_LOCK = 1'b1;
      n = 0;
      while (PLL_READY === 1'b1 && n < 10) begin tick(); n++; end
      loss_events++;
      exp_loss = (loss_events > LOSS_MAX) ? LOSS_MAX : loss_events;
      checks++;
      if (LOSS_CNT !== CNT_W'(exp_loss))
        $display("FAIL loss_count_%0d: got %0d expected %0d", loss_events, LOSS_CNT, exp_loss);
      else passes++;
    end
  endtask

  task automatic test_async_reset();
    int n;
    RESTART = 1'b1;
    tick();
    RESTART = 1'b0;
    n = 0;
    while (STATE !== 3'd2 && n < 20) begin tick(); n++; end
    repeat (3) tick();
    @(negedge Clock);
    #2;
    Reset_N = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== '0) $display("FAIL async_reset: got %h expected %h", dut_vec(), {VW{1'b0}});
    else passes++;
    repeat (2) tick();
    Reset_N  = 1'b1;
    PLL_LOCK = 1'b0;
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        PLL_LOCK = ($urandom_range(0, 99) < 70);
        hold = $urandom_range(1, 40);
      end
      hold--;
      RESTART = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if (dut_vec() !== model_vec())
        $display("FAIL random_cycle_%0d: got %h expected %h", c, dut_vec(), model_vec());
      else passes++;
    end
    RESTART = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss();
    test_stable_glitch();
    test_timeout_fail();
    test_restart();
    test_loss_saturation();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Controls a fabric PLL wrapper from the supervisor side of its lock/power-down interface. Drives the PLL's active-low power-down input, samples the asynchronous PLL_LOCK output through a synchroniser, qualifies lock over a stability window, and retries the PLL on timeout or loss of lock. Runs on the free-running PLL reference clock and provides ready, fabric-reset-request and status/counter outputs to the digitizer control logic.

Parameters:
PD_CYCLES, 16, cycles PLL_POWERDOWN_N is held low per (re)start attempt (>=2)
LOCK_TIMEOUT, 65535, max cycles in WAIT_LOCK before an attempt is declared failed
STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before READY
MAX_RETRIES, 7, failed attempts allowed before entering FAILED (1..15)
CNT_W, 8, width of the saturating lock-loss counter

Ports:
Clock  in  1  free-running reference clock, same net as the PLL REF_CLK
Reset_N  in  1  asynchronous active-low reset
PLL_LOCK  in  1  raw PLL lock, asynchronous to Clock
RESTART  in  1  single-cycle pulse: abort the current state and restart from PWRDN, clearing the retry count
PLL_POWERDOWN_N  out  1  to PLL power-down input; 0 = PLL held in power-down
PLL_READY  out  1  1 only in LOCKED
FABRIC_RESET_N  out  1  0 whenever not LOCKED; consumer synchronises into the PLL output domain
FAILED  out  1  1 in FAILED state
STATE  out  3  encoded state: PWRDN=0, WAIT_LOCK=1, STABLE=2, LOCKED=3, FAILED=4
RETRY_CNT  out  4  failed attempts since last reset/RESTART/successful lock
LOSS_CNT  out  CNT_W  saturating count of LOCKED->lock-lost events; cleared only by Reset_N

Behaviour:
- Reset (Reset_N=0, asynchronous): state=PWRDN, timer=0, PLL_POWERDOWN_N=0, PLL_READY=0, FABRIC_RESET_N=0, FAILED=0, RETRY_CNT=0, LOSS_CNT=0, synchroniser flops=0. Release is synchronous to the next Clock edge.
- PLL_LOCK passes through a 2-flop synchroniser; lock_s denotes the second flop. Latency from a PLL_LOCK edge to lock_s is 2-3 cycles.
- All outputs are registered and decoded from the next state. No combinational path exists from any input to any output.
- PWRDN: PLL_POWERDOWN_N=0; the timer counts to PD_CYCLES-1, then timer clears and the state moves to WAIT_LOCK. PLL_POWERDOWN_N=1 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - lock_s=1: go to STABLE, timer cleared.
  - timer reaches LOCK_TIMEOUT-1 with lock_s=0: RETRY_CNT+1. If the new value equals MAX_RETRIES, go to FAILED; otherwise go to PWRDN.
- STABLE:
  - lock_s=0 (glitch): go back to WAIT_LOCK, timer cleared. This does not count as a retry.
  - timer reaches STABLE_CYCLES-1 with lock_s=1: go to LOCKED and clear RETRY_CNT.
- LOCKED: PLL_READY=1, FABRIC_RESET_N=1. On lock_s=0: LOSS_CNT+1 (saturates at all-ones, no wrap), PLL_READY and FABRIC_RESET_N drop on the next cycle, and the state moves to PWRDN.
- FAILED: PLL_POWERDOWN_N=0, FAILED=1. The state holds until RESTART or reset.
- RESTART: valid in any state and has highest priority over all other transitions, including a simultaneous timeout or lock loss (no counter update in that cycle). Effect: next state=PWRDN, timer=0, RETRY_CNT=0, FAILED=0.
- The timer is a single shared counter, wide enough for max(PD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). It clears on every state change.

Decomposition:
- Package pll_sup_pkg:
  - state enum with the fixed encodings above
  - function for timer width: clog2 of the max parameter
- Sub-module sync_2ff: generic 2-flop synchroniser with asynchronous active-low reset, reusable elsewhere in the design for other asynchronous status bits.

Test Plan:
1. Reset release, PD_CYCLES=4, STABLE_CYCLES=8, PLL_LOCK raised 20 cycles after PLL_POWERDOWN_N rises:
   - PLL_POWERDOWN_N=0 for exactly 4 cycles after reset release.
   - PLL_READY=1 exactly 2+8 (+1 for synchroniser phase) cycles after the PLL_LOCK edge.
   - RETRY_CNT=0.
2. PLL_LOCK never asserts, LOCK_TIMEOUT=10, MAX_RETRIES=3:
   - three PWRDN/WAIT_LOCK cycles, then FAILED=1, STATE=4, RETRY_CNT=3.
   - PLL_POWERDOWN_N stays 0 while FAILED.
3. In LOCKED, drop PLL_LOCK for 1 cycle:
   - PLL_READY and FABRIC_RESET_N go low, LOSS_CNT=1, STATE returns to 0.
   - The supervisor relocks when PLL_LOCK is high again.
4. Lock glitch in STABLE (low for 2 cycles at timer=5):
   - STATE returns to 1, RETRY_CNT unchanged.
   - The stability window restarts from 0 after relock.
5. RESTART pulse in FAILED, and a RESTART pulse in the same cycle as a WAIT_LOCK timeout:
   - in both cases STATE=0 next cycle, RETRY_CNT=0, FAILED=0.
6. CNT_W=2, force 5 LOCKED->loss events: LOSS_CNT saturates at 3. Also assert Reset_N mid-STABLE: all outputs return to reset values immediately, asynchronously.
